// File: rtl/truth_sweep_checker.sv
// Exhaustive truth-table sweep engine: drives every input vector to a small combinational
// block, samples its response and compares it with EXPECT. Define SWEEP_MISR_EN for the Signature MISR.
module truth_sweep_checker #(
    parameter int N_IN = 4,
    parameter int SETTLE = 0,
    parameter logic [2**N_IN-1:0] EXPECT = {2**N_IN{1'b0}}
) (
    input  logic            Clk,
    input  logic            Reset,
    input  logic            Start,
    input  logic            Abort,
    input  logic            F,
    output logic [N_IN-1:0] Vec,
    output logic            Busy,
    output logic            Done,
    output logic            Pass,
    output logic [N_IN:0]   ErrCount,
    output logic [N_IN-1:0] FirstFail,
`ifdef SWEEP_MISR_EN
    output logic [15:0]     Signature,
`endif
    output logic [1:0]      DbgState
);

    // Control protocol: Start is a one-cycle request honoured only while the engine is not
    // busy (IDLE or DONE); Abort is honoured only while busy and beats a same-cycle final sample.
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] APPLY = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    localparam logic [7:0]      HOLD_LOAD = 8'(SETTLE);
    localparam logic [N_IN:0]   ERR_ONE   = (N_IN+1)'(1);
    localparam logic [N_IN-1:0] VEC_ONE   = N_IN'(1);

    logic [1:0]    state;
    logic [7:0]    holdCnt;
    logic          lastVec;
    logic          sampleNow;
    logic          mismatch;
    logic [N_IN:0] errNext;

    assign lastVec   = &Vec;
    assign sampleNow = (state == APPLY) && !Abort && (holdCnt == 8'd0);
    assign mismatch  = (F != EXPECT[Vec]);
    assign errNext   = mismatch ? ErrCount + ERR_ONE : ErrCount;

    assign Busy     = (state == APPLY);
    assign Done     = (state == DONE);
    assign DbgState = state;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state     <= IDLE;
            Vec       <= '0;
            holdCnt   <= 8'd0;
            Pass      <= 1'b0;
            ErrCount  <= '0;
            FirstFail <= '0;
        end else begin
            case (state)
                APPLY: begin
                    if (Abort) begin
                        state   <= IDLE;
                        Vec     <= '0;
                        holdCnt <= 8'd0;
                    end else if (holdCnt != 8'd0) begin
                        holdCnt <= holdCnt - 8'd1;
                    end else begin
                        ErrCount <= errNext;
                        if (mismatch && (ErrCount == '0)) begin
                            FirstFail <= Vec;
                        end
                        // Vec parks at 0 on the last vector instead of wrapping.
                        if (lastVec) begin
                            state <= DONE;
                            Vec   <= '0;
                            Pass  <= (errNext == '0);
                        end else begin
                            Vec     <= Vec + VEC_ONE;
                            holdCnt <= HOLD_LOAD;
                        end
                    end
                end
                default: begin
                    if (Start) begin
                        state     <= APPLY;
                        Vec       <= '0;
                        holdCnt   <= HOLD_LOAD;
                        Pass      <= 1'b0;
                        ErrCount  <= '0;
                        FirstFail <= '0;
                    end else begin
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

`ifdef SWEEP_MISR_EN
    logic misrFb;

    assign misrFb = Signature[15] ^ F;

    // Only sampled responses feed the MISR, so it freezes after DONE or Abort.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            Signature <= 16'hFFFF;
        end else if ((state != APPLY) && Start) begin
            Signature <= 16'hFFFF;
        end else if (sampleNow) begin
            Signature <= {Signature[14:0], 1'b0} ^ (misrFb ? 16'h1021 : 16'h0000);
        end
    end
`endif

endmodule
